// File: rtl/des_sbox_bank.sv
// des_sbox_bank
// DES substitution stage: applies S1..S8 to one 48-bit key-mixed word and
// returns the 32-bit result, evaluating LANES boxes per clock so a word takes
// 8/LANES cycles.
//
// Ports
//   clk                    clock, all state on rising edge
//   rst                    synchronous active-high reset
//   Sbox_Bank_Start        request; accepted in IDLE or DONE
//   Sbox_Bank_Input[48:1]  S1 takes [48:43] ... S8 takes [6:1]
//   Sbox_Bank_Busy         high while a word is in flight
//   Sbox_Bank_Output[32:1] S1 result in [32:29] ... S8 result in [4:1]
//   Sbox_Bank_Finish_Flag  one-cycle pulse when a new result is loaded
module des_sbox_bank #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Sbox_Bank_Start,
    input  logic [48:1] Sbox_Bank_Input,
    output logic        Sbox_Bank_Busy,
    output logic [32:1] Sbox_Bank_Output,
    output logic        Sbox_Bank_Finish_Flag
);
    localparam int NGRP  = 8 / LANES;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_bank: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [47:0]            in_q;
    logic [CNT_W-1:0]       cnt;
    logic [7:0][3:0]        acc;      // acc[k] holds the result of box S(k+1)
    logic [7:0][3:0]        acc_nxt;
    logic [31:0]            out_q;
    logic [31:0]            res_word;
    logic                   last_grp;
    logic                   accept;

    logic [7:0][5:0]        grp_all;  // grp_all[k] is the 6-bit field of S(k+1)
    logic [LANES-1:0][2:0]  box_idx;
    logic [LANES-1:0][5:0]  lane_grp;
    logic [LANES-1:0][3:0]  lane_res;

    assign last_grp = (cnt == CNT_W'(NGRP - 1));
    // DONE accepts a new word exactly like IDLE so Start held high streams.
    assign accept   = Sbox_Bank_Start && (state == IDLE || state == DONE);

    genvar k, l;
    generate
        for (k = 0; k < 8; k++) begin : g_field
            assign grp_all[k] = in_q[47-6*k -: 6];
        end

        // Lane l handles box cnt*LANES + l in the current cycle.
        for (l = 0; l < LANES; l++) begin : g_lane
            assign box_idx[l]  = 3'(int'(cnt) * LANES + l);
            assign lane_grp[l] = grp_all[box_idx[l]];

            des_sbox_lane u_lane (
                .box_idx (box_idx[l]),
                .grp     (lane_grp[l]),
                .res     (lane_res[l])
            );
        end
    endgenerate

    // Merge this cycle's lane results into the accumulator image.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < LANES; i++) begin
            acc_nxt[box_idx[i]] = lane_res[i];
        end
    end

    // S1 lands in the top nibble.
    always_comb begin
        res_word = '0;
        for (int i = 0; i < 8; i++) begin
            res_word[31-4*i -: 4] = acc_nxt[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Sbox_Bank_Start) state_nxt = RUN;
            RUN:     if (last_grp)        state_nxt = DONE;
            DONE:    state_nxt = Sbox_Bank_Start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        Sbox_Bank_Busy        = (state == RUN);
        Sbox_Bank_Finish_Flag = (state == DONE);
    end

    // Datapath. The output register is only written on the final group, so
    // partial accumulations never reach the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= '0;
            cnt   <= '0;
            acc   <= '0;
            out_q <= '0;
        end else if (accept) begin
            in_q <= Sbox_Bank_Input;
            cnt  <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            if (last_grp) begin
                cnt   <= '0;
                out_q <= res_word;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign Sbox_Bank_Output = out_q;

endmodule

// des_sbox_lane
// One S-box evaluator that can act as any of S1..S8.
//
// Ports
//   box_idx  0 selects S1 ... 7 selects S8
//   grp      6-bit input group b[6:1]
//   res      4-bit substitution result
module des_sbox_lane (
    input  logic [2:0] box_idx,
    input  logic [5:0] grp,
    output logic [3:0] res
);
    // Each table is 64 nibbles, row-major (row*16 + column), entry 0 in the
    // most significant nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    logic [5:0]   ent;
    logic [255:0] tbl;

    always_comb begin
        // row = {b6,b1}, column = b[5:2]
        ent = {grp[5], grp[0], grp[4:1]};
        case (box_idx)
            3'd0:    tbl = S1;
            3'd1:    tbl = S2;
            3'd2:    tbl = S3;
            3'd3:    tbl = S4;
            3'd4:    tbl = S5;
            3'd5:    tbl = S6;
            3'd6:    tbl = S7;
            default: tbl = S8;
        endcase
        // Entry e sits at bit 4*(63-e); ~ent == 63-ent for 6 bits.
        res = tbl[{~ent, 2'b00} +: 4];
    end

endmodule

// File: tb/tb_des_sbox_bank.sv
// Testbench for des_sbox_bank: four instances (LANES = 1, 2, 4, 8) share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_des_sbox_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] din;
    logic        busy [4];
    logic        fin  [4];
    logic [31:0] outv [4];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_bank #(.LANES(1 << g)) u_dut (
            .clk                   (clk),
            .rst                   (rst),
            .Sbox_Bank_Start       (start),
            .Sbox_Bank_Input       (din),
            .Sbox_Bank_Busy        (busy[g]),
            .Sbox_Bank_Output      (outv[g]),
            .Sbox_Bank_Finish_Flag (fin[g])
        );
    end

    // Standard DES S-boxes, [box][row*16 + column].
    localparam int SB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [31:0] sbox_ref(input logic [47:0] x);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int b, row, col;
            b   = int'((x >> (42 - 6 * k)) & 48'h3F);
            row = (b >> 5) * 2 + (b & 1);
            col = (b >> 1) & 15;
            r   = (r << 4) | 32'(SB[k][row * 16 + col]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level model: an accepted word is in flight for N = 8/LANES edges,
    // then its result appears with a one-cycle finish; a new word is accepted
    // whenever nothing is in flight.
    int          m_left [4] = '{0, 0, 0, 0};
    bit          m_fin  [4] = '{0, 0, 0, 0};
    logic [31:0] m_out  [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [47:0] m_word [4] = '{48'h0, 48'h0, 48'h0, 48'h0};

    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rst) begin
                m_left[g] = 0;
                m_fin[g]  = 1'b0;
                m_out[g]  = '0;
            end else if (m_left[g] > 0) begin
                m_left[g]--;
                m_fin[g] = 1'b0;
                if (m_left[g] == 0) begin
                    m_out[g] = sbox_ref(m_word[g]);
                    m_fin[g] = 1'b1;
                end
            end else begin
                m_fin[g] = 1'b0;
                if (start) begin
                    m_word[g] = din;
                    m_left[g] = 8 >> g;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("L%0d busy", 1 << g), 32'(busy[g]), 32'(m_left[g] > 0));
                chk($sformatf("L%0d finish", 1 << g), 32'(fin[g]), 32'(m_fin[g]));
                chk($sformatf("L%0d output", 1 << g), outv[g], m_out[g]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [47:0] w);
        din   = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        chk_en = 1'b1;
        for (int g = 0; g < 4; g++) begin
            chk("reset output", outv[g], 32'h0);
            chk("reset busy", 32'(busy[g]), 32'h0);
            chk("reset finish", 32'(fin[g]), 32'h0);
        end
        rst = 1'b0;
        tick();

        // All-zero and all-ones words.
        pulse(48'h0);
        repeat (10) tick();
        for (int g = 0; g < 4; g++) chk("zero word", outv[g], 32'hEFA72C4D);
        pulse(48'hFFFF_FFFF_FFFF);
        repeat (10) tick();
        for (int g = 0; g < 4; g++) chk("ones word", outv[g], 32'hD9CE3DCB);

        // Only the S1 field set: {b6,b1}=11, column 0 selects S1 row 3 col 0.
        pulse(48'h8400_0000_0000);
        repeat (10) tick();
        for (int g = 0; g < 4; g++) begin
            chk("S1 nibble", 32'(outv[g][31:28]), 32'(SB[0][48]));
            chk("S1 other nibbles", 32'(outv[g][27:0]), 32'h0FA72C4D);
        end

        // Start held high, input toggling every cycle (so it also changes
        // mid-RUN and Start is asserted throughout RUN).
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            din = i[0] ? 48'hFFFF_FFFF_FFFF : 48'h0;
            tick();
        end
        start = 1'b0;
        repeat (10) tick();

        // Reset during the second RUN cycle of the LANES=1 instance.
        pulse(48'h1234_5678_9ABC);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk("abort output", outv[g], 32'h0);
            chk("abort busy", 32'(busy[g]), 32'h0);
        end
        repeat (3) tick();
        pulse(48'hFEDC_BA98_7654);
        repeat (10) tick();
        for (int g = 0; g < 4; g++) chk("after abort", outv[g], sbox_ref(48'hFEDC_BA98_7654));

        // Random traffic with occasional resets.
        for (int i = 0; i < 20000; i++) begin
            start = ($urandom_range(0, 7) != 0);
            rst   = ($urandom_range(0, 499) == 0);
            din   = {16'($urandom), $urandom};
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
